mem_store_unit: RTL and testbench

//  Store-side data path and write master for the core's data memory port.

---
 rtl/mem_store_unit.sv | 123 ++++++++++++
 tb/tb_mem_store_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_store_unit.sv
// Store write master: aligns SB/SH/SW data into byte lanes, builds strobes and
// issues one or two word-aligned beats on a valid/ready write channel.
module mem_store_unit #(
    parameter int ADDR_W         = 32,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              done,
    output logic              fault,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state_q, state_d;
    logic              fault_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [31:0]       data_q;

    logic              accept;
    logic              bad_req;
    logic [3:0]        mask;
    logic [31:0]       data_m;
    logic [7:0]        strb8;
    logic [63:0]       data64;
    logic              split;
    logic [ADDR_W-1:0] beat0_addr;
    logic [ADDR_W-1:0] beat1_addr;

    // True when a legal store at this offset spills into the next word.
    function automatic logic crosses_word(input logic [2:0] f3, input logic [1:0] off);
        return (f3 == 3'd1 && off == 2'd3) || (f3 == 3'd2 && off != 2'd0);
    endfunction

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign bad_req   = (req_funct3 > 3'd2) ||
                       (!MISALIGN_SPLIT && crosses_word(req_funct3, req_addr[1:0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state_q <= state_d;
            if (accept) fault_q <= bad_req;
        end
    end

    // NOTE: payload flops are not reset; outputs are gated to 0 by state outside beats.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            data_q   <= req_data;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        mask = 4'b0000;
        case (funct3_q)
            3'd0:    mask = 4'b0001;
            3'd1:    mask = 4'b0011;
            3'd2:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        data_m     = data_q & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        strb8      = {4'b0000, mask} << addr_q[1:0];
        data64     = {32'b0, data_m} << {addr_q[1:0], 3'b000};
        split      = |strb8[7:4];
        beat0_addr = {addr_q[ADDR_W-1:2], 2'b00};
        beat1_addr = beat0_addr + ADDR_W'(4);
    end

    always_comb begin
        state_d    = state_q;
        done       = 1'b0;
        fault      = 1'b0;
        mem_wvalid = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = bad_req ? RESP : BEAT0;
            end
            BEAT0: begin
                mem_wvalid = 1'b1;
                mem_waddr  = beat0_addr;
                mem_wdata  = data64[31:0];
                mem_wstrb  = strb8[3:0];
                if (mem_wready) state_d = split ? BEAT1 : RESP;
            end
            BEAT1: begin
                mem_wvalid = 1'b1;
                mem_waddr  = beat1_addr;
                mem_wdata  = data64[63:32];
                mem_wstrb  = strb8[7:4];
                if (mem_wready) state_d = RESP;
            end
            RESP: begin
                done    = !fault_q && !rst;
                fault   = fault_q && !rst;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit: lane alignment, splits, back-pressure,
// address wrap, faults (both split modes) and mid-beat reset.
module tb_mem_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid2;
    logic        req_ready, req_ready2;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_data;
    logic        done, fault, done2, fault2;
    logic        mem_wvalid, mem_wvalid2;
    logic        mem_wready;
    logic [31:0] mem_waddr, mem_wdata, mem_waddr2, mem_wdata2;
    logic [3:0]  mem_wstrb, mem_wstrb2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_store_unit #(.ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data),
        .done(done), .fault(fault), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    mem_store_unit #(.ADDR_W(32), .MISALIGN_SPLIT(1'b0)) dut_nosplit (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data),
        .done(done2), .fault(fault2), .mem_wvalid(mem_wvalid2), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr2), .mem_wdata(mem_wdata2), .mem_wstrb(mem_wstrb2)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {wvalid, waddr, wdata, wstrb, done, fault, req_ready}
    function automatic logic [95:0] obs();
        return {24'b0, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, done, fault, req_ready};
    endfunction

    function automatic logic [95:0] obs2();
        return {24'b0, mem_wvalid2, mem_waddr2, mem_wdata2, mem_wstrb2, done2, fault2, req_ready2};
    endfunction

    function automatic logic [95:0] beat(input logic [31:0] a, input logic [31:0] d,
                                         input logic [3:0] s);
        return {24'b0, 1'b1, a, d, s, 3'b000};
    endfunction

    localparam logic [95:0] IDLE_OBS = 96'h1;      // only req_ready
    localparam logic [95:0] DONE_OBS = 96'h4;      // only done
    localparam logic [95:0] FLT_OBS  = 96'h2;      // only fault

    // Hold wready low for n cycles while checking the beat is stable, then accept it.
    task automatic beat_wait(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int n);
        mem_wready = 1'b0;
        for (int i = 0; i < n; i++) begin
            check({tag, "_hold"}, obs(), beat(a, d, s));
            @(negedge clk);
        end
        mem_wready = 1'b1;
        check(tag, obs(), beat(a, d, s));
        @(negedge clk);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input int nbeats, input int stall,
                             input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                             input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_data = d;
        @(negedge clk);
        req_valid = 1'b0;
        beat_wait({tag, "_b0"}, a0, d0, s0, stall);
        if (nbeats == 2) beat_wait({tag, "_b1"}, a1, d1, s1, stall);
        check({tag, "_done"}, obs(), DONE_OBS);
        @(negedge clk);
        check({tag, "_idle"}, obs(), IDLE_OBS);
    endtask

    task automatic run_fault(input string tag, input logic [2:0] f3, input logic [31:0] a);
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_data = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_fault"}, obs(), FLT_OBS);
        @(negedge clk);
        check({tag, "_idle"}, obs(), IDLE_OBS);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; mem_wready = 1'b1;
        req_funct3 = 3'd0; req_addr = '0; req_data = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", obs(), 96'h0);
        check("reset_outputs2", obs2(), 96'h0);
        rst = 1'b0;
        #1 check("ready_after_reset", {95'b0, req_ready}, 96'h1);
        @(negedge clk);

        // Single-beat stores, issued back to back
        run_store("sw_aligned", 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 1, 0,
                  32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'h0, 4'h0);
        run_store("sb_off3", 3'd0, 32'h0000_0103, 32'h1234_56AB, 1, 0,
                  32'h100, 32'hAB00_0000, 4'b1000, 32'h0, 32'h0, 4'h0);
        run_store("sh_off2", 3'd1, 32'h0000_0102, 32'h1234_BEEF, 1, 0,
                  32'h100, 32'hBEEF_0000, 4'b1100, 32'h0, 32'h0, 4'h0);
        run_store("sb_off1", 3'd0, 32'h0000_0301, 32'hFFFF_FF5A, 1, 0,
                  32'h300, 32'h0000_5A00, 4'b0010, 32'h0, 32'h0, 4'h0);

        // Split stores
        run_store("sh_split", 3'd1, 32'h0000_0203, 32'h0000_CAFE, 2, 0,
                  32'h200, 32'hFE00_0000, 4'b1000, 32'h204, 32'h0000_00CA, 4'b0001);
        run_store("sw_off3", 3'd2, 32'h0000_0103, 32'h1122_3344, 2, 0,
                  32'h100, 32'h4400_0000, 4'b1000, 32'h104, 32'h0011_2233, 4'b0111);
        run_store("sw_stall", 3'd2, 32'h0000_0102, 32'hDEAD_BEEF, 2, 5,
                  32'h100, 32'hBEEF_0000, 4'b1100, 32'h104, 32'h0000_DEAD, 4'b0011);
        run_store("sw_wrap", 3'd2, 32'hFFFF_FFFE, 32'hA5A5_1234, 2, 0,
                  32'hFFFF_FFFC, 32'h1234_0000, 4'b1100, 32'h0, 32'h0000_A5A5, 4'b0011);

        // Illegal funct3
        run_fault("f3_3", 3'd3, 32'h0000_0100);
        run_fault("f3_7", 3'd7, 32'h0000_0104);

        // Split disabled: crossing stores fault, non-crossing ones still write
        req_valid2 = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0000_0102; req_data = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid2 = 1'b0;
        check("nosplit_sw_fault", obs2(), FLT_OBS);
        check("nosplit_other_quiet", obs(), IDLE_OBS);
        @(negedge clk);
        check("nosplit_sw_idle", obs2(), IDLE_OBS);
        req_valid2 = 1'b1; req_funct3 = 3'd1; req_addr = 32'h0000_0203; req_data = 32'h0000_CAFE;
        @(negedge clk);
        req_valid2 = 1'b0;
        check("nosplit_sh_fault", obs2(), FLT_OBS);
        @(negedge clk);
        req_valid2 = 1'b1; req_funct3 = 3'd0; req_addr = 32'h0000_0103; req_data = 32'h0000_0077;
        @(negedge clk);
        req_valid2 = 1'b0;
        check("nosplit_sb_beat", obs2(), beat(32'h100, 32'h7700_0000, 4'b1000));
        @(negedge clk);
        check("nosplit_sb_done", obs2(), DONE_OBS);
        @(negedge clk);

        // Reset while BEAT1 is stalled
        mem_wready = 1'b0;
        req_valid = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0000_0102; req_data = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        mem_wready = 1'b1;
        @(negedge clk);
        check("rst_pre_beat1", obs(), beat(32'h104, 32'h0000_DEAD, 4'b0011));
        mem_wready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_abandon", obs(), 96'h0);
        rst = 1'b0;
        #1 check("rst_ready_on_drop", {95'b0, req_ready}, 96'h1);
        mem_wready = 1'b1;
        @(negedge clk);
        check("rst_no_done", obs(), IDLE_OBS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
